// File: rtl/fetch_redirect_unit.sv
// Fetch front end: PC generation, one-deep memory request pipeline, 2-entry
// instruction queue and branch redirect. Optional stats counters under FETCH_STATS_EN.
module fetch_redirect_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [15:0]        redirect_count,
  output logic [15:0]        stall_count
);

  // Handshake: an instruction transfers to decode on a cycle where
  // if_valid && id_ready; if_valid never depends on id_ready.

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [1:0]         count_q, count_d;
  logic [INSTR_W-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [ADDR_W-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;
  logic               pop, push, issue;
  logic [2:0]         occupancy;
  logic               unused_target_lsbs;

  assign unused_target_lsbs = ^br_target[1:0];

  // Slot 0 is always the queue head, so decode sees plain register outputs.
  assign if_valid  = (count_q != 2'd0);
  assign if_instr  = instr0_q;
  assign if_pc     = pc0_q;
  assign pop       = if_valid && id_ready;
  assign push      = inflight_q && !br_taken;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  // rst_n gates the request so nothing is issued while held in reset.
  assign issue     = rst_n && !br_taken && (occupancy < 3'd2);
  assign imem_req  = issue;
  assign imem_addr = pc_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    instr0_d      = instr0_q;
    instr1_d      = instr1_q;
    pc0_d         = pc0_q;
    pc1_d         = pc1_q;
    if (issue) begin
      pc_d          = pc_q + ADDR_W'(4);
      inflight_pc_d = pc_q;
    end
    if (pop) begin
      instr0_d = instr1_q;
      pc0_d    = pc1_q;
      count_d  = count_d - 2'd1;
    end
    // Insert at the first free slot after the pop has shifted the queue.
    if (push) begin
      if (count_d == 2'd0) begin
        instr0_d = imem_rdata;
        pc0_d    = inflight_pc_q;
      end else begin
        instr1_d = imem_rdata;
        pc1_d    = inflight_pc_q;
      end
      count_d = count_d + 2'd1;
    end
    if (br_taken) begin
      count_d = 2'd0;
      pc_d    = {br_target[ADDR_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      instr0_q      <= '0;
      instr1_q      <= '0;
      pc0_q         <= '0;
      pc1_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      instr0_q      <= instr0_d;
      instr1_q      <= instr1_d;
      pc0_q         <= pc0_d;
      pc1_q         <= pc1_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] redirect_count_q, stall_count_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count_q <= 16'd0;
      stall_count_q    <= 16'd0;
    end else begin
      if (br_taken && (redirect_count_q != 16'hFFFF))
        redirect_count_q <= redirect_count_q + 16'd1;
      if (if_valid && !id_ready && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign redirect_count = redirect_count_q;
  assign stall_count    = stall_count_q;
`else
  assign redirect_count = 16'd0;
  assign stall_count    = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: stimulus queues expected {pc, instr}
// pairs, a negedge monitor checks every decode handshake against them.
module tb_fetch_redirect_unit;
  localparam int          ADDR_W  = 32;
  localparam int          INSTR_W = 32;
  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [31:0] XOR_PAT = 32'hA5A5_A5A5;
`ifdef FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               id_ready = 1'b0;
  logic               br_taken = 1'b0;
  logic [ADDR_W-1:0]  br_target = '0;
  logic [15:0]        redirect_count;
  logic [15:0]        stall_count;

  logic [63:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  fetch_redirect_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .br_taken(br_taken), .br_target(br_target),
    .redirect_count(redirect_count), .stall_count(stall_count)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ XOR_PAT;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ XOR_PAT});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL handshake: got pc %h expected no transfer", if_pc);
      end else begin
        check("handshake", {if_pc, if_instr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Scenario 1: reset values, startup latency, full-rate streaming
    id_ready = 1'b1;
    cycle(); cycle(); settle();
    check("rst_req",    64'(imem_req),       64'd0);
    check("rst_addr",   64'(imem_addr),      64'(RST_PC));
    check("rst_valid",  64'(if_valid),       64'd0);
    check("rst_instr",  64'(if_instr),       64'd0);
    check("rst_pc",     64'(if_pc),          64'd0);
    check("rst_redir",  64'(redirect_count), 64'd0);
    check("rst_stall",  64'(stall_count),    64'd0);
    cycle(); rst_n = 1'b1;                                   // C0
    expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108); expect_pc(32'h10C);
    settle();
    check("c0_req",  64'(imem_req),  64'd1);
    check("c0_addr", 64'(imem_addr), 64'(RST_PC));
    cycle(); settle();                                       // C1
    check("c1_valid", 64'(if_valid),  64'd0);
    check("c1_addr",  64'(imem_addr), 64'h104);
    cycle(); settle();                                       // C2
    check("c2_valid", 64'(if_valid), 64'd1);
    check("c2_pc",    64'(if_pc),    64'h100);
    cycle(); cycle(); cycle();                               // C5
    cycle(); id_ready = 1'b0;                                // C6

    // Scenario 2: decode stalls 5 cycles after first valid
    rst_n = 1'b0;
    cycle(); cycle(); rst_n = 1'b1;                          // C0
    expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
    cycle();                                                 // C1
    cycle(); settle();                                       // C2
    check("stall_c2_req", 64'(imem_req), 64'd0);
    cycle(); settle();                                       // C3
    check("stall_c3_req",   64'(imem_req), 64'd0);
    check("stall_c3_valid", 64'(if_valid), 64'd1);
    cycle(); cycle(); cycle(); settle();                     // C6
    check("stall_c6_pc",  64'(if_pc),    64'h100);
    check("stall_c6_req", 64'(imem_req), 64'd0);
    cycle(); id_ready = 1'b1; settle();                      // C7
    check("release_req",  64'(imem_req),  64'd1);
    check("release_addr", 64'(imem_addr), 64'h108);
    cycle(); cycle();                                        // C9
    cycle(); id_ready = 1'b0;                                // C10

    // Scenario 3: redirects (with handshake, with full queue), wrap, stats, async reset
    rst_n = 1'b0;
    cycle(); cycle(); rst_n = 1'b1; id_ready = 1'b1;         // C0
    expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h200); expect_pc(32'h204);
    expect_pc(32'hFFFF_FFFC); expect_pc(32'h0000_0000);
    cycle(); cycle();                                        // C2
    cycle(); br_taken = 1'b1; br_target = 32'h300; settle(); // C3: 0x104 handshakes too
    check("redir1_req", 64'(imem_req), 64'd0);
    cycle(); br_taken = 1'b0; settle();                      // C4
    check("redir1_bubble1", 64'(if_valid),  64'd0);
    check("redir1_addr",    64'(imem_addr), 64'h300);
    cycle(); settle();                                       // C5
    check("redir1_bubble2", 64'(if_valid), 64'd0);
    cycle(); id_ready = 1'b0; settle();                      // C6
    check("redir1_target_pc", 64'(if_pc), 64'h300);
    cycle(); cycle();                                        // C8
    cycle(); br_taken = 1'b1; br_target = 32'h203; settle(); // C9: queue full
    check("redir2_req", 64'(imem_req), 64'd0);
    cycle(); br_taken = 1'b0; id_ready = 1'b1; settle();     // C10
    check("redir2_addr",    64'(imem_addr), 64'h200);
    check("redir2_bubble1", 64'(if_valid),  64'd0);
    cycle();                                                 // C11
    cycle();                                                 // C12
    cycle(); br_taken = 1'b1; br_target = 32'hFFFF_FFFC;     // C13: 0x204 handshakes too
    cycle(); br_taken = 1'b0; settle();                      // C14
    check("redirect_count", 64'(redirect_count), STATS ? 64'd3 : 64'd0);
    check("stall_count",    64'(stall_count),    STATS ? 64'd4 : 64'd0);
    check("top_addr",       64'(imem_addr),      64'hFFFF_FFFC);
    cycle(); settle();                                       // C15
    check("wrap_req",  64'(imem_req),  64'd1);
    check("wrap_addr", 64'(imem_addr), 64'h0);
    cycle(); cycle();                                        // C17
    cycle(); id_ready = 1'b0; #2 rst_n = 1'b0; #1;           // C18
    check("async_req",   64'(imem_req),       64'd0);
    check("async_addr",  64'(imem_addr),      64'(RST_PC));
    check("async_valid", 64'(if_valid),       64'd0);
    check("async_instr", 64'(if_instr),       64'd0);
    check("async_pc",    64'(if_pc),          64'd0);
    check("async_redir", 64'(redirect_count), 64'd0);
    check("async_stall", 64'(stall_count),    64'd0);

    // Scenario 4: back-to-back redirects, later target wins
    cycle(); cycle(); rst_n = 1'b1; id_ready = 1'b1;         // C0
    expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h600); expect_pc(32'h604);
    cycle(); cycle();                                        // C2
    cycle(); br_taken = 1'b1; br_target = 32'h500;           // C3
    cycle(); br_target = 32'h600; settle();                  // C4
    check("b2b_req",   64'(imem_req), 64'd0);
    check("b2b_valid", 64'(if_valid), 64'd0);
    cycle(); br_taken = 1'b0; settle();                      // C5
    check("b2b_addr", 64'(imem_addr), 64'h600);
    cycle(); settle();                                       // C6
    check("b2b_bubble2", 64'(if_valid), 64'd0);
    cycle(); settle();                                       // C7
    check("b2b_target_pc", 64'(if_pc), 64'h600);
    cycle();                                                 // C8
    cycle(); id_ready = 1'b0; settle();                      // C9
    check("b2b_redirect_count", 64'(redirect_count), STATS ? 64'd2 : 64'd0);
    cycle(); cycle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
